// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: STAGES register stages, each adding one CHUNK-bit
// slice of the operands and handing its carry to the next stage.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;

  // Handshake: a beat transfers on a rising edge where valid & ready are both 1;
  // a producer holding valid keeps its data stable until that edge. in_ready is
  // combinational from out_ready so a full pipeline can accept and retire together.

  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] r_c;
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic              r_cmsb;

  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_v_src;
  logic [STAGES-1:0] w_c_nxt;
  logic [WIDTH-1:0]  w_a_nxt   [STAGES];
  logic [WIDTH-1:0]  w_b_nxt   [STAGES];
  logic [WIDTH-1:0]  w_sum_nxt [STAGES];
  logic              w_cmsb_nxt;

  // load[i] = !v[i] | adv[i] with adv[i] = v[i] & load[i+1], which reduces to !v[i] | load[i+1].
  always_comb begin : advance
    logic downstream_load;
    w_load          = '0;
    downstream_load = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_load[i]       = !r_v[i] | downstream_load;
      downstream_load = w_load[i];
    end
  end

  // Operands travel pre-shifted so the chunk a stage needs is always at the LSBs.
  always_comb begin : datapath
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_sum;
    logic             src_c;
    logic [CHUNK:0]   part;
    int               prev;
    w_v_src    = '0;
    w_c_nxt    = '0;
    w_cmsb_nxt = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      prev = (i > 0) ? i - 1 : 0;
      if (i == 0) begin
        src_a      = a;
        src_b      = b;
        src_sum    = '0;
        src_c      = cin;
        w_v_src[i] = in_valid;
      end else begin
        src_a      = r_a[prev];
        src_b      = r_b[prev];
        src_sum    = r_sum[prev];
        src_c      = r_c[prev];
        w_v_src[i] = r_v[prev];
      end
      part = {1'b0, src_a[CHUNK-1:0]} + {1'b0, src_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, src_c};
      w_sum_nxt[i] = src_sum | (WIDTH'(part[CHUNK-1:0]) << (CHUNK * i));
      w_a_nxt[i]   = src_a >> CHUNK;
      w_b_nxt[i]   = src_b >> CHUNK;
      w_c_nxt[i]   = part[CHUNK];
      // Carry into the MSB recovered from the MSB's own sum bit.
      if (i == STAGES - 1)
        w_cmsb_nxt = src_a[CHUNK-1] ^ src_b[CHUNK-1] ^ part[CHUNK-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v    <= '0;
      r_c    <= '0;
      r_cmsb <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        r_a[i]   <= '0;
        r_b[i]   <= '0;
        r_sum[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (w_load[i]) begin
          r_v[i] <= w_v_src[i];
          // Data registers only move with a real beat, so an empty stage keeps its last value.
          if (w_v_src[i]) begin
            r_a[i]   <= w_a_nxt[i];
            r_b[i]   <= w_b_nxt[i];
            r_sum[i] <= w_sum_nxt[i];
            r_c[i]   <= w_c_nxt[i];
            if (i == STAGES - 1)
              r_cmsb <= w_cmsb_nxt;
          end
        end
      end
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_v[STAGES-1];
  assign sum       = r_sum[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign overflow  = r_cmsb ^ r_c[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: a 16-bit/4-stage instance with a queue scoreboard and
// a 1-bit/1-stage instance checked against the full-adder truth table.
module tb_pipelined_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  logic fa_in_valid, fa_in_ready, fa_a, fa_b, fa_cin;
  logic fa_out_valid, fa_out_ready, fa_sum, fa_cout, fa_overflow;

  int checks   = 0;
  int failures = 0;

  logic [W+1:0] exp_q[$];
  logic         hold_pend = 1'b0;
  logic [W+1:0] hold_val  = '0;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  pipelined_adder #(.WIDTH(1), .STAGES(1)) u_fa (
    .clk(clk), .rst_n(rst_n),
    .in_valid(fa_in_valid), .in_ready(fa_in_ready),
    .a(fa_a), .b(fa_b), .cin(fa_cin),
    .out_valid(fa_out_valid), .out_ready(fa_out_ready),
    .sum(fa_sum), .cout(fa_cout), .overflow(fa_overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // {cout, overflow, sum}; overflow from the sign rule, independent of carries.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] full;
    logic       ov;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    ov   = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {full[W], ov, full[W-1:0]};
  endfunction

  // scoreboard / monitor
  always @(negedge clk) begin
    logic [W+1:0] expv;
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_hold", 32'({cout, overflow, sum}), 32'(hold_val));
      end
      if (out_valid && out_ready) begin
        check("out_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          expv = exp_q.pop_front();
          check("scoreboard", 32'({cout, overflow, sum}), 32'(expv));
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = {cout, overflow, sum};
    end
  end

  // driver tasks: entered and left at posedge+1
  task automatic cycle_drive(input logic v, input logic [W-1:0] xa, input logic [W-1:0] xb,
                             input logic xc, input logic ordy, output logic acc);
    in_valid  = v;
    a         = xa;
    b         = xb;
    cin       = xc;
    out_ready = ordy;
    @(negedge clk);
    acc = in_valid & in_ready;
    if (acc) exp_q.push_back(model(xa, xb, xc));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++)
      cycle_drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic single_beat(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                             input logic xc, input logic [W-1:0] es, input logic ec, input logic eo);
    logic acc;
    cycle_drive(1'b1, xa, xb, xc, 1'b1, acc);
    in_valid = 1'b0;
    check({tag, "_accept"}, 32'(acc), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    check({tag, "_early"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(overflow), 32'(eo));
  endtask

  initial begin
    logic         acc;
    int           idx;
    int           cyc;
    logic [W-1:0] ba[6];
    logic [W-1:0] bb[6];
    logic         bc[6];
    logic [W-1:0] xa, xb;
    logic         xc;
    logic         fs, fc;

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    fa_in_valid = 1'b0; fa_a = 1'b0; fa_b = 1'b0; fa_cin = 1'b0; fa_out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_fa_out_valid", 32'(fa_out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // directed single beats
    single_beat("t1a", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    single_beat("t1b", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    single_beat("t1c", 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);
    drain();

    // back-to-back stream
    for (int i = 0; i < 100; i++) begin
      cycle_drive(1'b1, W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 1)), 1'b1, acc);
      check("stream_in_ready", 32'(acc), 32'd1);
    end
    drain();

    // backpressure: 6 beats offered into a stalled pipeline
    for (int i = 0; i < 6; i++) begin
      ba[i] = W'($urandom_range(0, 65535));
      bb[i] = W'($urandom_range(0, 65535));
      bc[i] = 1'($urandom_range(0, 1));
    end
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      cycle_drive(1'b1, ba[idx], bb[idx], bc[idx], 1'b0, acc);
      if (acc) idx++;
    end
    check("bp_accepted", 32'(idx), 32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    cyc = 0;
    while (idx < 6 && cyc < 20) begin
      cycle_drive(1'b1, ba[idx], bb[idx], bc[idx], 1'b1, acc);
      if (acc) idx++;
      cyc++;
    end
    check("bp_all_accepted", 32'(idx), 32'd6);
    drain();

    // random valid/ready toggling
    idx = 0;
    cyc = 0;
    xa = W'($urandom_range(0, 65535));
    xb = W'($urandom_range(0, 65535));
    xc = 1'($urandom_range(0, 1));
    while (idx < 1000 && cyc < 20000) begin
      cycle_drive(1'($urandom_range(0, 1)), xa, xb, xc, 1'($urandom_range(0, 1)), acc);
      if (acc) begin
        idx++;
        xa = W'($urandom_range(0, 65535));
        xb = W'($urandom_range(0, 65535));
        xc = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    check("rand_beats", 32'(idx), 32'd1000);
    drain();

    // reset with beats in flight
    for (int i = 0; i < 3; i++)
      cycle_drive(1'b1, W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)), 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    single_beat("t5", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
    drain();

    // 1-bit, 1-stage full adder truth table
    for (int k = 0; k < 8; k++) begin
      fa_in_valid = 1'b1;
      fa_a   = k[2];
      fa_b   = k[1];
      fa_cin = k[0];
      fs = k[2] ^ k[1] ^ k[0];
      fc = (k[2] & k[1]) | (k[2] & k[0]) | (k[1] & k[0]);
      @(posedge clk);
      #1;
      check("fa_valid", 32'(fa_out_valid), 32'd1);
      check("fa_sum", 32'(fa_sum), 32'(fs));
      check("fa_cout", 32'(fa_cout), 32'(fc));
      check("fa_ovf", 32'(fa_overflow), 32'((k[2] == k[1]) && (fs != k[2])));
    end
    fa_in_valid = 1'b0;
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
